// File: rtl/claw_play_sequencer.sv
// claw_play_sequencer
// Turns the one-cycle strength/balance result codes from the claw machine credit
// FSM into a timed claw cycle (drop, grip, lift, carry, release) and a coin-refund
// handshake with the hopper. The claw and refund FSMs run independently.
//
// Optional feature macro: CLAW_SLIP_EN
//   When defined, grip_level decays by one every SLIP_PERIOD cycles across LIFT and
//   MOVE; reaching 0 pulses prize_lost and opens the jaws for the rest of MOVE.
//   When undefined, grip_level holds the latched strength and prize_lost is tied 0.
//
// Ports:
//   clk           clock
//   rstn          synchronous active-low reset
//   strength      catch request 1..9 (0 = none, 10..15 rejected)
//   balance       refund request 1..12 (0 = none)
//   coin_ack      hopper accepted one coin
//   busy          claw FSM not IDLE
//   motor_down    lower claw (DROP)
//   motor_up      raise claw (LIFT)
//   claw_close    jaws closed (GRIP, LIFT, MOVE unless slipped)
//   carriage_move drive carriage to chute (MOVE)
//   grip_level    grip strength for the jaw driver
//   catch_done    pulse during RELEASE
//   req_err       pulse when a catch request is rejected
//   coin_req      ask hopper for one coin
//   coins_left    coins still owed (saturates at 31)
//   refund_done   pulse when coins_left reaches 0
//   prize_lost    pulse when grip decays to 0 (CLAW_SLIP_EN only)
//
// Claw FSM states:
//   state   | meaning
//   IDLE    | waiting for a strength request
//   DROP    | motor_down for DROP_CYC cycles
//   GRIP    | jaws closing for GRIP_CYC cycles
//   LIFT    | motor_up with jaws closed for LIFT_CYC cycles
//   MOVE    | carriage to chute for MOVE_CYC cycles
//   RELEASE | one cycle, jaws open, catch_done
//
// Refund FSM states:
//   state   | meaning
//   R_IDLE  | nothing owed
//   R_PAY   | coin_req held until coins_left drains to 0

module claw_play_sequencer #(
    parameter int DROP_CYC    = 8,
    parameter int GRIP_CYC    = 4,
    parameter int LIFT_CYC    = 8,
    parameter int MOVE_CYC    = 12,
    parameter int SLIP_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] strength,
    input  logic [3:0] balance,
    input  logic       coin_ack,
    output logic       busy,
    output logic       motor_down,
    output logic       motor_up,
    output logic       claw_close,
    output logic       carriage_move,
    output logic [3:0] grip_level,
    output logic       catch_done,
    output logic       req_err,
    output logic       coin_req,
    output logic [4:0] coins_left,
    output logic       refund_done,
    output logic       prize_lost
);

    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DROP    = 3'd1,
        GRIP    = 3'd2,
        LIFT    = 3'd3,
        MOVE    = 3'd4,
        RELEASE = 3'd5
    } claw_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_PAY  = 1'b1
    } refund_state_t;

    claw_state_t   claw_state, claw_next;
    refund_state_t r_state, r_next;
    logic [CW-1:0] phase;
    logic          strength_ok;
    logic          accept;
    logic          slipped;
    logic          pay_take;
    logic [5:0]    coin_sum;
    logic [4:0]    coins_next;

    assign strength_ok = (strength != 4'd0) && (strength <= 4'd9);
    assign accept      = (claw_state == IDLE) && strength_ok;

    // ---------------- claw FSM ----------------
    always_ff @(posedge clk) begin
        if (!rstn) claw_state <= IDLE;
        else       claw_state <= claw_next;
    end

    always_comb begin
        claw_next = claw_state;
        case (claw_state)
            IDLE:    if (strength_ok)     claw_next = DROP;
            DROP:    if (phase == '0)     claw_next = GRIP;
            GRIP:    if (phase == '0)     claw_next = LIFT;
            LIFT:    if (phase == '0)     claw_next = MOVE;
            MOVE:    if (phase == '0)     claw_next = RELEASE;
            RELEASE:                      claw_next = IDLE;
            default:                      claw_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        motor_down    = 1'b0;
        motor_up      = 1'b0;
        claw_close    = 1'b0;
        carriage_move = 1'b0;
        case (claw_state)
            DROP: begin
                busy       = 1'b1;
                motor_down = 1'b1;
            end
            GRIP: begin
                busy       = 1'b1;
                claw_close = 1'b1;
            end
            LIFT: begin
                busy       = 1'b1;
                motor_up   = 1'b1;
                claw_close = 1'b1;
            end
            MOVE: begin
                busy          = 1'b1;
                carriage_move = 1'b1;
                claw_close    = !slipped;
            end
            RELEASE: busy = 1'b1;
            default: ;
        endcase
    end

    // Phase down-counter: loaded with (duration-1) on every state entry, so the
    // state advances on the cycle the counter reads zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase <= '0;
        end else if (claw_next != claw_state) begin
            case (claw_next)
                DROP:    phase <= CW'(DROP_CYC - 1);
                GRIP:    phase <= CW'(GRIP_CYC - 1);
                LIFT:    phase <= CW'(LIFT_CYC - 1);
                MOVE:    phase <= CW'(MOVE_CYC - 1);
                default: phase <= '0;
            endcase
        end else if (phase != '0) begin
            phase <= phase - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            catch_done <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            catch_done <= (claw_next == RELEASE);
            req_err    <= (strength != 4'd0) && !accept;
        end
    end

`ifdef CLAW_SLIP_EN
    // Slip timer runs across LIFT and MOVE without reloading at the MOVE boundary.
    logic [CW-1:0] slip_cnt;
    logic          slip_tick;

    assign slip_tick = ((claw_state == LIFT) || (claw_state == MOVE)) && (slip_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            slip_cnt   <= '0;
            slipped    <= 1'b0;
            prize_lost <= 1'b0;
            grip_level <= 4'd0;
        end else begin
            if ((claw_state == GRIP) && (claw_next == LIFT))
                slip_cnt <= CW'(SLIP_PERIOD - 1);
            else if (slip_tick)
                slip_cnt <= CW'(SLIP_PERIOD - 1);
            else if (slip_cnt != '0)
                slip_cnt <= slip_cnt - 1'b1;

            prize_lost <= slip_tick && (grip_level == 4'd1);

            if (claw_state == IDLE)
                slipped <= 1'b0;
            else if (slip_tick && (grip_level == 4'd1))
                slipped <= 1'b1;

            // RELEASE clearing wins over a decay tick landing on the same edge.
            if (accept)
                grip_level <= strength;
            else if (claw_next == RELEASE)
                grip_level <= 4'd0;
            else if (slip_tick && (grip_level != 4'd0))
                grip_level <= grip_level - 4'd1;
        end
    end
`else
    assign slipped    = 1'b0;
    assign prize_lost = 1'b0;

    always_ff @(posedge clk) begin
        if (!rstn)
            grip_level <= 4'd0;
        else if (accept)
            grip_level <= strength;
        else if (claw_next == RELEASE)
            grip_level <= 4'd0;
    end
`endif

    // ---------------- refund FSM ----------------
    // coin_req implies coins_left > 0, so the subtraction never underflows;
    // the 6-bit sum (max 31+12) is clamped to 31.
    assign pay_take   = coin_req && coin_ack;
    assign coin_sum   = {1'b0, coins_left} + {2'b00, balance} - {5'b0, pay_take};
    assign coins_next = (coin_sum > 6'd31) ? 5'd31 : coin_sum[4:0];

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (coins_next != 5'd0) r_next = R_PAY;
            R_PAY:   if (coins_next == 5'd0) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        coin_req = (r_state == R_PAY);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            coins_left  <= 5'd0;
            refund_done <= 1'b0;
        end else begin
            coins_left  <= coins_next;
            refund_done <= (r_state == R_PAY) && (coins_next == 5'd0);
        end
    end

endmodule

// File: tb/tb_claw_play_sequencer.sv
module tb_claw_play_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] strength;
    logic [3:0] balance;
    logic       coin_ack;
    logic       busy, motor_down, motor_up, claw_close, carriage_move;
    logic [3:0] grip_level;
    logic       catch_done, req_err, coin_req, refund_done, prize_lost;
    logic [4:0] coins_left;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    claw_play_sequencer dut (
        .clk(clk), .rstn(rstn), .strength(strength), .balance(balance), .coin_ack(coin_ack),
        .busy(busy), .motor_down(motor_down), .motor_up(motor_up), .claw_close(claw_close),
        .carriage_move(carriage_move), .grip_level(grip_level), .catch_done(catch_done),
        .req_err(req_err), .coin_req(coin_req), .coins_left(coins_left),
        .refund_done(refund_done), .prize_lost(prize_lost)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] claw_vec();
        return {busy, motor_down, motor_up, claw_close, carriage_move,
                catch_done, prize_lost, grip_level};
    endfunction

    // Expected claw outputs at cycle c after a request of strength s (cycle 0 = request edge).
    function automatic logic [10:0] exp_vec(input int c, input int s);
        int   decs;
        int   g;
        logic b, md, mu, cc, cm, cd, pl;
        decs = 0;
        pl   = 1'b0;
`ifdef CLAW_SLIP_EN
        if (c >= 17) decs = (c - 13) / 4;
        if (c >= 17 && c <= 33 && ((c - 13) % 4) == 0 && decs == s) pl = 1'b1;
`endif
        b  = (c >= 1 && c <= 33);
        md = (c >= 1 && c <= 8);
        mu = (c >= 13 && c <= 20);
        cm = (c >= 21 && c <= 32);
        cd = (c == 33);
        cc = (c >= 9 && c <= 20) || (cm && (s - decs) > 0);
        g  = s - decs;
        if (g < 0) g = 0;
        if (!(c >= 1 && c <= 32)) g = 0;
        return {b, md, mu, cc, cm, cd, pl, 4'(g)};
    endfunction

    task automatic run_profile(input int s);
        strength = 4'(s);
        tick();
        strength = 4'd0;
        for (int c = 1; c <= 34; c++) begin
            chk($sformatf("profile s=%0d c=%0d", s, c), 32'(claw_vec()), 32'(exp_vec(c, s)));
            if (c < 34) tick();
        end
    endtask

    initial begin
        int seen;
        int guard;
        rstn     = 1'b0;
        strength = 4'd0;
        balance  = 4'd0;
        coin_ack = 1'b0;
        tick();
        tick();
        chk("reset claw", 32'(claw_vec()), 32'd0);
        chk("reset refund", {26'd0, req_err, coin_req, refund_done, coins_left}, 32'd0);
        rstn = 1'b1;

        // reset mid-DROP
        strength = 4'd4;
        tick();
        strength = 4'd0;
        tick();
        tick();
        chk("middrop busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        chk("middrop reset", 32'(claw_vec()), 32'd0);
        rstn = 1'b1;

        // full cycles; each next request lands in the cycle after RELEASE
        run_profile(4);
        run_profile(3);
        run_profile(6);
        run_profile(5);
        run_profile(9);

        // second request mid-cycle is dropped
        strength = 4'd7;
        tick();
        strength = 4'd0;
        for (int i = 0; i < 9; i++) tick();
        strength = 4'd2;
        tick();
        strength = 4'd0;
        chk("drop err", 32'(req_err), 32'd1);
        chk("drop grip", 32'(grip_level), 32'd7);
        seen  = 0;
        guard = 0;
        while (busy && guard < 40) begin
            if (catch_done) seen++;
            tick();
            guard++;
        end
        chk("drop idle", 32'(busy), 32'd0);
        chk("drop done count", 32'(seen), 32'd1);

        // out-of-range strength in IDLE
        strength = 4'd12;
        tick();
        strength = 4'd0;
        chk("reject err", 32'(req_err), 32'd1);
        chk("reject busy", 32'(busy), 32'd0);
        tick();
        chk("reject err clr", 32'(req_err), 32'd0);

        // refund with ack every other cycle: {coins_left, coin_req, refund_done}
        balance = 4'd3;
        tick();
        balance = 4'd0;
        chk("refund b3", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd3, 1'b1, 1'b0});
        coin_ack = 1'b1; tick();
        chk("refund a1", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd2, 1'b1, 1'b0});
        coin_ack = 1'b0; tick();
        chk("refund n1", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd2, 1'b1, 1'b0});
        coin_ack = 1'b1; tick();
        chk("refund a2", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd1, 1'b1, 1'b0});
        coin_ack = 1'b0; tick();
        chk("refund n2", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd1, 1'b1, 1'b0});
        coin_ack = 1'b1; tick();
        chk("refund a3", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd0, 1'b0, 1'b1});
        tick();
        chk("refund stray ack", {25'd0, coins_left, coin_req, refund_done}, {25'd0, 5'd0, 1'b0, 1'b0});
        coin_ack = 1'b0;

        // saturation: 12+12+6 = 30, then ack with balance 5 -> 34 clamps to 31
        balance = 4'd12; tick();
        balance = 4'd12; tick();
        balance = 4'd6;  tick();
        chk("sat 30", 32'(coins_left), 32'd30);
        balance  = 4'd5;
        coin_ack = 1'b1;
        tick();
        balance = 4'd0;
        chk("sat 31", 32'(coins_left), 32'd31);
        seen  = 0;
        guard = 0;
        while (coin_req && guard < 40) begin
            seen++;
            tick();
            guard++;
        end
        coin_ack = 1'b0;
        chk("sat drain count", 32'(seen), 32'd31);
        chk("sat drain done", {30'd0, refund_done, coin_req}, {30'd0, 1'b1, 1'b0});

        // both paths in the same cycle
        strength = 4'd5;
        balance  = 4'd2;
        tick();
        strength = 4'd0;
        balance  = 4'd0;
        chk("both claw", {27'd0, busy, grip_level}, {27'd0, 1'b1, 4'd5});
        chk("both coins", {26'd0, coin_req, coins_left}, {26'd0, 1'b1, 5'd2});
        coin_ack = 1'b1;
        tick();
        tick();
        coin_ack = 1'b0;
        chk("both refund done", {25'd0, coins_left, refund_done, busy}, {25'd0, 5'd0, 1'b1, 1'b1});
        guard = 0;
        while (busy && guard < 40) begin
            tick();
            guard++;
        end
        chk("both claw idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
